multiplier_nbits_seq: RTL and testbench
=======================================

Name: multiplier_nbits_seq

Overview:
- Parametrised sequential shift-add multiplier that generalises the 8-bit multiplier control unit.
- Control unit and datapath are in a single block.
- Supports any operand width and both unsigned and signed (two's complement) operands.
- Uses a start/DONE handshake and sits between an operand source and a result consumer in the arithmetic subsystem.

Parameters:
- WIDTH, 8, operand width in bits; legal values are WIDTH >= 2. Product width is 2*WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-low reset. 0 clears all state immediately, regardless of clk.
- start  input  1  level request; sampled only in IDLE.
- SIGNED  input  1  1 = operands are two's complement, 0 = unsigned; sampled together with X and Y.
- X  input  WIDTH  multiplicand.
- Y  input  WIDTH  multiplier.
- BUSY  output  1  high in LOAD, CALC and FIN.
- DONE  output  1  one-cycle pulse, asserted in FIN.
- RES  output  2*WIDTH  product register; holds its value until the next FIN.

Behaviour:
- One clock domain, single always block for state, plus next-state logic.
- Reset (RESET=0, asynchronous):
  - state=IDLE, RES=0, DONE=0, BUSY=0, counter=0, internal registers=0.
  - Deassertion takes effect at the next rising edge.
  - Reset during any state aborts the operation; RES returns to 0.
- States:
  - IDLE: BUSY=0. If start=1 at an edge: capture X, Y, SIGNED; go to LOAD. Otherwise stay.
  - LOAD (1 cycle): compute operand magnitudes.
    - Signed mode: |v| for negative v, and neg_flag = X[WIDTH-1] ^ Y[WIDTH-1].
    - Unsigned mode: operands unchanged, neg_flag=0.
    - Clear the accumulator (2*WIDTH bits) and counter; go to CALC.
  - CALC (exactly WIDTH cycles):
    - Each edge: if the multiplier LSB is 1, accumulator += multiplicand shifted left by the counter.
    - Then shift the multiplier right by 1 and increment the counter.
    - When counter reaches WIDTH-1 at the edge, go to FIN.
    - No early termination: cycle count is constant.
  - FIN (1 cycle):
    - RES is loaded on the edge entering FIN: accumulator, or its two's complement if neg_flag=1.
    - DONE=1 during FIN; next state is IDLE.
- Latency: start sampled at edge k → DONE high during the cycle following edge k+WIDTH+1.
  - Total request-to-DONE is WIDTH+2 cycles.
  - RES is valid from that same cycle onward.
- start held high continuously: a new operation begins at the first edge in IDLE after FIN, so the issue interval is WIDTH+3 cycles.
- start while BUSY=1 is ignored. X/Y/SIGNED changes while busy have no effect.
- Arithmetic:
  - Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), which fits unsigned in WIDTH bits; no overflow.
  - Signed min*min = 2^(2*WIDTH-2) is correct in 2*WIDTH bits.
  - Zero result with neg_flag=1 yields 0; negating 0 gives 0.
- The counter is sized to hold WIDTH-1.
- No latches; all outputs are registered except BUSY and DONE, which are decoded from state.

Test Plan:
- WIDTH=8, RESET low 2 cycles then high; start=1, SIGNED=0, X=13, Y=11 → DONE pulses once, exactly 10 cycles after start sampled; RES=143 (0x008F); BUSY high for 10 cycles.
- WIDTH=8 unsigned X=255, Y=255 → RES=65025 (0xFE01). Then X=0, Y=200 → RES=0.
- WIDTH=8 signed:
  - X=-3 (0xFD), Y=5 → RES=0xFFF1.
  - X=-128, Y=-128 → RES=0x4000.
  - X=-128, Y=127 → RES=0xC080.
- start held at 1 with operands changing every cycle → only the operands present at each IDLE sample are used; DONE pulses every 11 cycles; no extra pulses.
- Reset mid-CALC: RESET=0 four cycles after start → RES=0, BUSY=0, DONE=0 immediately, without waiting for clk. After release, next start X=7, Y=6 → RES=42 with normal latency.
- WIDTH=16 instance, unsigned X=0xFFFF, Y=0xFFFF → RES=0xFFFE0001 after 18 cycles. Signed X=0x8000, Y=0x0002 → RES=0xFFFF0000.

Source files
------------

// File: rtl/multiplier_nbits_seq.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, unsigned or two's complement.
// Signed operands are reduced to magnitudes, multiplied, and the product is negated at the end.
module multiplier_nbits_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 RESET,
    input  logic                 start,
    input  logic                 SIGNED,
    input  logic [WIDTH-1:0]     X,
    input  logic [WIDTH-1:0]     Y,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   RES
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StLoad, StCalc, StFin} state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [WIDTH-1:0]     r_x;
    logic [WIDTH-1:0]     r_y;
    logic                 r_sgn;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic                 r_neg;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CW-1:0]        r_cnt;
    logic [2*WIDTH-1:0]   r_res;

    logic [WIDTH-1:0]     w_x_mag;
    logic [WIDTH-1:0]     w_y_mag;
    logic [2*WIDTH-1:0]   w_addend;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic                 w_last;

    // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude.
    assign w_x_mag   = (r_sgn && r_x[WIDTH-1]) ? -r_x : r_x;
    assign w_y_mag   = (r_sgn && r_y[WIDTH-1]) ? -r_y : r_y;
    assign w_addend  = {{WIDTH{1'b0}}, r_mcand} << r_cnt;
    assign w_acc_nxt = r_mplier[0] ? (r_acc + w_addend) : r_acc;
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        BUSY        = 1'b1;
        DONE        = 1'b0;
        unique case (r_state)
            StIdle: begin
                BUSY = 1'b0;
                if (start) begin
                    w_state_nxt = StLoad;
                end
            end
            StLoad: w_state_nxt = StCalc;
            StCalc: begin
                if (w_last) begin
                    w_state_nxt = StFin;
                end
            end
            StFin: begin
                DONE        = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            r_x      <= '0;
            r_y      <= '0;
            r_sgn    <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_res    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (start) begin
                        r_x   <= X;
                        r_y   <= Y;
                        r_sgn <= SIGNED;
                    end
                end
                StLoad: begin
                    r_mcand  <= w_x_mag;
                    r_mplier <= w_y_mag;
                    r_neg    <= r_sgn & (r_x[WIDTH-1] ^ r_y[WIDTH-1]);
                    r_acc    <= '0;
                    r_cnt    <= '0;
                end
                StCalc: begin
                    r_acc    <= w_acc_nxt;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    // The last partial product lands in the result on the same edge.
                    if (w_last) begin
                        r_res <= r_neg ? -w_acc_nxt : w_acc_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign RES = r_res;

endmodule

// File: tb/tb_multiplier_nbits_seq.sv
// Directed bench for multiplier_nbits_seq: an 8-bit and a 16-bit instance on a shared clock/reset.
// Inputs are driven and outputs sampled on the falling edge.
module tb_multiplier_nbits_seq;

    logic        clk;
    logic        rst_n;
    logic        start8;
    logic        sgn8;
    logic [7:0]  x8;
    logic [7:0]  y8;
    logic        busy8;
    logic        done8;
    logic [15:0] res8;
    logic        start16;
    logic        sgn16;
    logic [15:0] x16;
    logic [15:0] y16;
    logic        busy16;
    logic        done16;
    logic [31:0] res16;

    int checks = 0;
    int errors = 0;

    multiplier_nbits_seq #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .RESET  (rst_n),
        .start  (start8),
        .SIGNED (sgn8),
        .X      (x8),
        .Y      (y8),
        .BUSY   (busy8),
        .DONE   (done8),
        .RES    (res8)
    );

    multiplier_nbits_seq #(.WIDTH(16)) u_dut16 (
        .clk    (clk),
        .RESET  (rst_n),
        .start  (start16),
        .SIGNED (sgn16),
        .X      (x16),
        .Y      (y16),
        .BUSY   (busy16),
        .DONE   (done16),
        .RES    (res16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_done(input bit wide);
        return wide ? done16 : done8;
    endfunction

    function automatic logic get_busy(input bit wide);
        return wide ? busy16 : busy8;
    endfunction

    function automatic logic [31:0] get_res(input bit wide);
        return wide ? res16 : {16'h0, res8};
    endfunction

    // One full operation: checks busy, request-to-DONE latency, product, and DONE being one cycle.
    task automatic run_op(input bit wide, input logic [15:0] x, input logic [15:0] y,
                          input logic sgn, input logic [31:0] exp, input string tag);
        int lat;
        int w;
        int busy_cnt;
        w = wide ? 16 : 8;
        @(negedge clk);
        if (wide) begin
            start16 = 1'b1; x16 = x; y16 = y; sgn16 = sgn;
        end else begin
            start8 = 1'b1; x8 = x[7:0]; y8 = y[7:0]; sgn8 = sgn;
        end
        @(negedge clk);
        // Operands scrambled while busy must not matter.
        start8 = 1'b0; start16 = 1'b0;
        x8 = ~x[7:0]; y8 = ~y[7:0]; sgn8 = ~sgn;
        x16 = ~x; y16 = ~y; sgn16 = ~sgn;
        lat = 1;
        busy_cnt = get_busy(wide) ? 1 : 0;
        while (!get_done(wide) && lat < 64) begin
            @(negedge clk);
            lat++;
            if (get_busy(wide)) busy_cnt++;
        end
        check({tag, " latency"}, lat, w + 2);
        check({tag, " busy cycles"}, busy_cnt, w + 2);
        check({tag, " res"}, get_res(wide), exp);
        @(negedge clk);
        check({tag, " done pulse"}, {31'h0, get_done(wide)}, 32'h0);
        check({tag, " idle"}, {31'h0, get_busy(wide)}, 32'h0);
        check({tag, " res held"}, get_res(wide), exp);
    endtask

    initial begin
        int pulses;
        int last_pulse;
        int s;
        rst_n = 1'b0;
        start8 = 1'b0; sgn8 = 1'b0; x8 = '0; y8 = '0;
        start16 = 1'b0; sgn16 = 1'b0; x16 = '0; y16 = '0;
        repeat (2) @(negedge clk);
        check("reset res8", {16'h0, res8}, 32'h0);
        check("reset busy8", {31'h0, busy8}, 32'h0);
        check("reset done8", {31'h0, done8}, 32'h0);
        check("reset res16", res16, 32'h0);
        rst_n = 1'b1;

        run_op(1'b0, 16'd13, 16'd11, 1'b0, 32'h008F, "u8 13x11");
        run_op(1'b0, 16'd255, 16'd255, 1'b0, 32'hFE01, "u8 255x255");
        run_op(1'b0, 16'd0, 16'd200, 1'b0, 32'h0000, "u8 0x200");
        run_op(1'b0, 16'h00FD, 16'h0005, 1'b1, 32'hFFF1, "s8 -3x5");
        run_op(1'b0, 16'h0080, 16'h0080, 1'b1, 32'h4000, "s8 min x min");
        run_op(1'b0, 16'h0080, 16'h007F, 1'b1, 32'hC080, "s8 min x max");
        run_op(1'b0, 16'h0000, 16'h00FB, 1'b1, 32'h0000, "s8 0x-5");
        run_op(1'b0, 16'h00FF, 16'h00FF, 1'b1, 32'h0001, "s8 -1x-1");

        // start held high, operands changing every cycle: operation begins at j=0,11,22.
        pulses = 0;
        last_pulse = -1;
        for (int j = 0; j <= 32; j++) begin
            @(negedge clk);
            if (done8) begin
                pulses++;
                s = j - 10;
                check("stream res", {16'h0, res8}, 32'((s + 1) * (s + 2)));
                if (last_pulse >= 0) check("stream interval", j - last_pulse, 11);
                last_pulse = j;
            end
            if (j < 32) begin
                start8 = 1'b1; sgn8 = 1'b0;
                x8 = 8'(j + 1); y8 = 8'(j + 2);
            end else begin
                start8 = 1'b0;
            end
        end
        check("stream pulses", pulses, 3);
        repeat (3) @(negedge clk);
        check("stream settled", {31'h0, busy8}, 32'h0);

        // Asynchronous reset four cycles into an operation, away from any clock edge.
        @(negedge clk);
        start8 = 1'b1; x8 = 8'd9; y8 = 8'd9; sgn8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        check("pre-reset busy", {31'h0, busy8}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async res", {16'h0, res8}, 32'h0);
        check("async busy", {31'h0, busy8}, 32'h0);
        check("async done", {31'h0, done8}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 16'd7, 16'd6, 1'b0, 32'd42, "u8 after reset");

        run_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "u16 max x max");
        run_op(1'b1, 16'h8000, 16'h0002, 1'b1, 32'hFFFF0000, "s16 min x 2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
